washing_machine_ctrl: RTL
=========================

// Module: washing_machine_ctrl
// PURPOSE
//  Parametrised washing-machine sequencer. Runs one soap wash, then RINSE_CYCLES water rinses, then a timed spin.
//  Wash and spin durations come from internal down-counters, not external timeout strobes.
//  Adds a user stop/abort path and a fill-watchdog fault. Sits between the front-panel/sensor inputs and the valve/motor drivers.
// PARAMETERS
//  RINSE_CYCLES  2     number of water-rinse passes after the soap wash (>=1)
//  WASH_TIME     1000  cycles the motor runs in each WASH pass (>=1)
//  SPIN_TIME     500   cycles of final spin (>=1)
//  FILL_TIMEOUT  4000  max cycles in FILL without `filled` before fault (>=1)
//  TIMER_W       16    timer width; must hold max(WASH_TIME,SPIN_TIME,FILL_TIMEOUT)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  door_close     in   1   door sensor, 1 = closed
//  start          in   1   start request, level sampled in IDLE
//  stop           in   1   user abort request
//  filled         in   1   water-level-full sensor
//  det_added      in   1   detergent-loaded sensor
//  drained        in   1   water-empty sensor
//  pause          in   1   only with WM_PAUSE_EN
//  door_lock      out  1   door latch
//  motor_on       out  1   drum motor
//  fill_valve_on  out  1   inlet valve
//  drain_valve_on out  1   outlet valve
//  soap_wash      out  1   1 during WASH on pass 0
//  water_wash     out  1   1 during WASH on pass >=1
//  done           out  1   1-cycle pulse, program completed
//  aborted        out  1   1-cycle pulse, stop-initiated drain completed
//  fault          out  1   sticky fill-watchdog fault
//  state          out  3   current state code
//  pass           out  $clog2(RINSE_CYCLES+1)  0 = soap pass, k = rinse k
// BEHAVIOUR
//  Encoding: IDLE=0, FILL=1, DETERGENT=2, WASH=3, DRAIN=4, SPIN=5, DONE=6, FAULT=7.
//  State, pass, timer and abort flag are registered. Outputs are a pure decode of the registered state/pass.
//  There is no input-to-output combinational path.
//  Reset: state=IDLE, pass=0, timer=0, abort flag=0, every output 0.
//  IDLE: all outputs 0. If start&door_close, go to FILL next edge with pass=0. start with door open is ignored.
//  FILL: door_lock=1, fill_valve_on=1, timer counts up from 0.
//   - filled: go to DETERGENT if pass==0, else WASH.
//   - timer reaches FILL_TIMEOUT-1 without filled: go to FAULT.
//  DETERGENT: door_lock=1. On det_added go to WASH. No timeout.
//  WASH: door_lock=1, motor_on=1, soap_wash/water_wash per pass.
//   - Timer loads WASH_TIME-1 on entry; state is held exactly WASH_TIME cycles, then goes to DRAIN.
//  DRAIN: door_lock=1, drain_valve_on=1. On drained:
//   - abort flag set: go to IDLE, pulse aborted, clear pass and flag.
//   - else pass<RINSE_CYCLES: pass++, go to FILL.
//   - else: go to SPIN.
//  SPIN: door_lock=1, motor_on=1, drain_valve_on=1. Held exactly SPIN_TIME cycles, then goes to DONE.
//  DONE: one cycle, done=1, door_lock=0. Then go to IDLE with pass=0.
//  FAULT: fault=1, door_lock=1, drain_valve_on=1, all else 0. Exits only via reset.
//  Stop: sampled in FILL, DETERGENT or WASH. Sets the abort flag and goes to DRAIN next edge, cancelling the timer.
//   - stop is ignored in IDLE, DRAIN, SPIN, DONE and FAULT.
//  Priority within one cycle: reset > stop > fill timeout > normal transition.
//   - Example: stop and filled in the same FILL cycle goes to DRAIN.
//  door_close falling while locked is ignored (door is latched).
//  Reset mid-program returns to IDLE next edge with all valves and the motor off.
// CONFIGURATION
//  WM_PAUSE_EN defined:
//   - `pause` port exists.
//   - While pause=1 in WASH or SPIN: timer frozen, motor_on=0, state held; door_lock stays 1.
//   - Resuming continues the remaining count. stop still overrides pause.
//  WM_PAUSE_EN undefined: no `pause` port; timers never freeze.
// TESTING  (RINSE_CYCLES=1, WASH_TIME=4, SPIN_TIME=3, FILL_TIMEOUT=8)
//  Full program: start+door_close, filled, det_added, filled, drained each 1 cycle when waited for.
//   -> sequence FILL, DET, WASH(soap, 4 cyc), DRAIN, FILL, WASH(water, 4 cyc), DRAIN, SPIN(3 cyc), DONE.
//   -> done high 1 cycle; door_lock=0 after.
//  start=1 with door_close=0 for 10 cycles -> state stays 0, all outputs 0.
//  Fill watchdog: start, filled held 0 -> FAULT after 8 FILL cycles; fault=1 sticky until reset.
//  Stop in 2nd WASH cycle -> DRAIN next edge; drained -> aborted pulse, IDLE, pass=0, done never set.
//  Reset asserted during SPIN -> next edge state=0, motor_on=0, drain_valve_on=0, door_lock=0.
//  WM_PAUSE_EN: pause 5 cycles mid-WASH -> motor_on=0 during pause; WASH lasts 4+5 cycles total.

Source files
------------

// File: rtl/washing_machine_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : washing_machine_ctrl
//  Purpose  : Washing-machine program sequencer. Runs one soap wash, then
//             RINSE_CYCLES water rinses, then a timed spin. Wash and spin
//             durations come from an internal down-counter; fill is guarded
//             by a watchdog that latches a fault. A user stop drains the drum
//             and returns to idle with an 'aborted' pulse.
//  Ports    : clk, reset (sync, active-high)
//             door_close, start, stop, filled, det_added, drained  - inputs
//             pause (only when WM_PAUSE_EN is defined)              - input
//             door_lock, motor_on, fill_valve_on, drain_valve_on,
//             soap_wash, water_wash, done, aborted, fault           - outputs
//             state [2:0], pass [PASS_W-1:0]                        - status
//  Config   : WM_PAUSE_EN - adds the pause port; a registered pause freezes
//             the WASH/SPIN timer and stops the motor.
//  Revision : 1.0 - initial release
// ============================================================================
module washing_machine_ctrl #(
    parameter int RINSE_CYCLES = 2,
    parameter int WASH_TIME    = 1000,
    parameter int SPIN_TIME    = 500,
    parameter int FILL_TIMEOUT = 4000,
    parameter int TIMER_W      = 16,
    localparam int PASS_W      = $clog2(RINSE_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              door_close,
    input  logic              start,
    input  logic              stop,
    input  logic              filled,
    input  logic              det_added,
    input  logic              drained,
`ifdef WM_PAUSE_EN
    input  logic              pause,
`endif
    output logic              door_lock,
    output logic              motor_on,
    output logic              fill_valve_on,
    output logic              drain_valve_on,
    output logic              soap_wash,
    output logic              water_wash,
    output logic              done,
    output logic              aborted,
    output logic              fault,
    output logic [2:0]        state,
    output logic [PASS_W-1:0] pass
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FILL      = 3'd1,
        S_DETERGENT = 3'd2,
        S_WASH      = 3'd3,
        S_DRAIN     = 3'd4,
        S_SPIN      = 3'd5,
        S_DONE      = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    localparam logic [TIMER_W-1:0] c_WASH_LOAD = TIMER_W'(WASH_TIME - 1);
    localparam logic [TIMER_W-1:0] c_SPIN_LOAD = TIMER_W'(SPIN_TIME - 1);
    localparam logic [TIMER_W-1:0] c_FILL_LAST = TIMER_W'(FILL_TIMEOUT - 1);
    localparam logic [PASS_W-1:0]  c_LAST_PASS = PASS_W'(RINSE_CYCLES);

    state_t              state_q,   state_d;
    logic [PASS_W-1:0]   pass_q,    pass_d;
    logic [TIMER_W-1:0]  timer_q,   timer_d;
    logic                abort_q,   abort_d;    // current program was stopped by the user
    logic                aborted_q, aborted_d;  // one-cycle completion pulse of an abort drain
    logic                w_paused;

`ifdef WM_PAUSE_EN
    // Pause is registered so that motor_on stays a pure register decode;
    // freezing and motor-off therefore both act one cycle after pause.
    logic pause_q, pause_d;
    always_comb pause_d = pause;
    assign w_paused = pause_q;
`else
    assign w_paused = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pass_q    <= '0;
            timer_q   <= '0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
`ifdef WM_PAUSE_EN
            pause_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            timer_q   <= timer_d;
            abort_q   <= abort_d;
            aborted_q <= aborted_d;
`ifdef WM_PAUSE_EN
            pause_q   <= pause_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Stop has priority over the fill watchdog, which
    // has priority over the normal transitions.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        timer_d   = timer_q;
        abort_d   = abort_q;
        aborted_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && door_close) begin
                    state_d = S_FILL;
                    pass_d  = '0;
                    timer_d = '0;
                end
            end

            S_FILL: begin
                if (stop) begin
                    state_d = S_DRAIN;
                    abort_d = 1'b1;
                    timer_d = '0;
                end else if (filled) begin
                    // Only the first pass needs detergent loaded.
                    state_d = (pass_q == '0) ? S_DETERGENT : S_WASH;
                    timer_d = c_WASH_LOAD;
                end else if (timer_q == c_FILL_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            S_DETERGENT: begin
                if (stop) begin
                    state_d = S_DRAIN;
                    abort_d = 1'b1;
                    timer_d = '0;
                end else if (det_added) begin
                    state_d = S_WASH;
                    timer_d = c_WASH_LOAD;
                end
            end

            S_WASH: begin
                if (stop) begin
                    state_d = S_DRAIN;
                    abort_d = 1'b1;
                    timer_d = '0;
                end else if (!w_paused) begin
                    if (timer_q == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
            end

            S_DRAIN: begin
                if (drained) begin
                    if (abort_q) begin
                        state_d   = S_IDLE;
                        pass_d    = '0;
                        abort_d   = 1'b0;
                        aborted_d = 1'b1;
                    end else if (pass_q < c_LAST_PASS) begin
                        state_d = S_FILL;
                        pass_d  = pass_q + PASS_W'(1);
                        timer_d = '0;
                    end else begin
                        state_d = S_SPIN;
                        timer_d = c_SPIN_LOAD;
                    end
                end
            end

            S_SPIN: begin
                if (!w_paused) begin
                    if (timer_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                pass_d  = '0;
            end

            S_FAULT: begin
                // Only reset leaves FAULT.
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from registered state only.
    // ------------------------------------------------------------------
    always_comb begin
        door_lock      = 1'b0;
        motor_on       = 1'b0;
        fill_valve_on  = 1'b0;
        drain_valve_on = 1'b0;
        soap_wash      = 1'b0;
        water_wash     = 1'b0;
        done           = 1'b0;
        fault          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
            end
            S_FILL: begin
                door_lock     = 1'b1;
                fill_valve_on = 1'b1;
            end
            S_DETERGENT: begin
                door_lock = 1'b1;
            end
            S_WASH: begin
                door_lock  = 1'b1;
                motor_on   = !w_paused;
                soap_wash  = (pass_q == '0);
                water_wash = (pass_q != '0);
            end
            S_DRAIN: begin
                door_lock      = 1'b1;
                drain_valve_on = 1'b1;
            end
            S_SPIN: begin
                door_lock      = 1'b1;
                motor_on       = !w_paused;
                drain_valve_on = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            S_FAULT: begin
                fault          = 1'b1;
                door_lock      = 1'b1;
                drain_valve_on = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign aborted = aborted_q;
    assign state   = state_q;
    assign pass    = pass_q;

endmodule
`default_nettype wire
